// File: rtl/random_clk_gen.sv
// Random-period clock generator: each high/low phase lasts MIN_HALF + i_lfsr[RANGE_BITS-1:0] cycles.
// Optional rising-edge counter port o_edge_cnt is enabled by defining RANDCLK_EDGE_CNT_EN.
module random_clk_gen #(
  parameter int unsigned BW_LFSR    = 8,
  parameter int unsigned RANGE_BITS = 3,
  parameter int unsigned MIN_HALF   = 2,
  parameter int unsigned BW_CNT     = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic [BW_LFSR-1:0] i_lfsr,
  output logic               o_clk,
  output logic               o_rise,
  output logic               o_fall,
`ifdef RANDCLK_EDGE_CNT_EN
  output logic [15:0]        o_edge_cnt,
`endif
  output logic               o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BW_CNT-1:0] cnt_q, cnt_d;
  logic [BW_CNT-1:0] load_val;
  logic              rise_d, fall_d;

  // Counter holds N-1 so that a value of 0 marks the last cycle of the phase.
  assign load_val = BW_CNT'(MIN_HALF - 1) + BW_CNT'(i_lfsr[RANGE_BITS-1:0]);

  generate
    if (RANGE_BITS < BW_LFSR) begin : g_unused_lfsr
      logic unused_lfsr_bits;
      assign unused_lfsr_bits = ^i_lfsr[BW_LFSR-1:RANGE_BITS];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = HIGH;
          cnt_d   = load_val;
          rise_d  = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BW_CNT'(1);
        end else begin
          state_d = LOW;
          cnt_d   = load_val;
          fall_d  = 1'b1;
        end
      end
      LOW: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - BW_CNT'(1);
        end else if (i_en) begin
          state_d = HIGH;
          cnt_d   = load_val;
          rise_d  = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state so they line up with the state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_clk   <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_clk   <= (state_d == HIGH);
      o_rise  <= rise_d;
      o_fall  <= fall_d;
      o_busy  <= (state_d != IDLE);
    end
  end

`ifdef RANDCLK_EDGE_CNT_EN
  logic [15:0] edge_cnt;

  // Saturating count, updated on the same edge that raises o_rise.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      edge_cnt <= '0;
    end else if (rise_d && (edge_cnt != '1)) begin
      edge_cnt <= edge_cnt + 16'd1;
    end
  end

  assign o_edge_cnt = edge_cnt;
`endif

endmodule

// File: tb/tb_random_clk_gen.sv
// Self-checking bench for random_clk_gen: directed scenarios plus randomized stimulus vs. a phase-level model.
module tb_random_clk_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] lfsr_in;
  logic       o_clk, o_rise, o_fall, o_busy;
`ifdef RANDCLK_EDGE_CNT_EN
  logic [15:0] o_edge_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: tracks whether a waveform is running, its level, and cycles left in the phase.
  bit m_active, m_clk, m_rise, m_fall;
  int m_left;

  always #5 clk = ~clk;

  random_clk_gen #(
    .BW_LFSR(8),
    .RANGE_BITS(3),
    .MIN_HALF(2),
    .BW_CNT(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_lfsr(lfsr_in),
    .o_clk(o_clk),
    .o_rise(o_rise),
    .o_fall(o_fall),
`ifdef RANDCLK_EDGE_CNT_EN
    .o_edge_cnt(o_edge_cnt),
`endif
    .o_busy(o_busy)
  );

  function automatic int phase_len(input logic [7:0] v);
    return 2 + int'(v % 8);
  endfunction

  function automatic void model_edge(input bit r, input bit e, input logic [7:0] v);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (r) begin
      m_active = 1'b0;
      m_clk    = 1'b0;
      m_left   = 0;
    end else if (!m_active) begin
      if (e) begin
        m_active = 1'b1;
        m_clk    = 1'b1;
        m_rise   = 1'b1;
        m_left   = phase_len(v);
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        if (m_clk) begin
          m_clk  = 1'b0;
          m_fall = 1'b1;
          m_left = phase_len(v);
        end else if (e) begin
          m_clk  = 1'b1;
          m_rise = 1'b1;
          m_left = phase_len(v);
        end else begin
          m_active = 1'b0;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge(rst, en, lfsr_in);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    en      = 1'b1;
    lfsr_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if ({o_clk, o_rise, o_fall, o_busy} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got clk/rise/fall/busy=%b expected 0000", i,
                 {o_clk, o_rise, o_fall, o_busy});
      end
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

  task automatic test_single_period();
    int rises = 0, falls = 0, busy_cycles = 0;
    do_reset();
    lfsr_in = 8'h05;
    en      = 1'b1;
    tick();
    en = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      tests++;
      if (o_clk !== (t <= 7)) begin
        fails++;
        $display("FAIL single_clk t=%0d: got %b expected %b", t, o_clk, (t <= 7));
      end
      tests++;
      if (o_busy !== (t <= 14)) begin
        fails++;
        $display("FAIL single_busy t=%0d: got %b expected %b", t, o_busy, (t <= 14));
      end
      rises += int'(o_rise);
      falls += int'(o_fall);
      busy_cycles += int'(o_busy);
      tick();
    end
    tests++;
    if (rises != 1 || falls != 1 || busy_cycles != 14) begin
      fails++;
      $display("FAIL single_counts: got rises=%0d falls=%0d busy=%0d expected 1 1 14",
               rises, falls, busy_cycles);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] vals [2];
    vals[0] = 8'hF8;
    vals[1] = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      int n;
      do_reset();
      lfsr_in = vals[k];
      en      = 1'b1;
      n       = phase_len(vals[k]);
      for (int t = 1; t <= 4 * n; t++) begin
        tick();
        tests++;
        if (o_clk !== ((((t - 1) / n) % 2) == 0)) begin
          fails++;
          $display("FAIL extreme_clk lfsr=%0h t=%0d: got %b expected %b", vals[k], t, o_clk,
                   ((((t - 1) / n) % 2) == 0));
        end
      end
    end
    en = 1'b0;
  endtask

  task automatic test_lfsr_driven();
    logic [7:0] s = 8'h01;
    int exp_q[$];
    int run = 0;
    bit started = 1'b0;
    logic prev = 1'b0;
    do_reset();
    en = 1'b1;
    for (int c = 0; c < 500; c++) begin
      lfsr_in = s;
      tick();
      if (m_rise || m_fall) exp_q.push_back(phase_len(s));
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
      if (o_clk !== prev) begin
        if (started) begin
          tests++;
          if (exp_q.size() == 0 || run != exp_q[0] || run < 2) begin
            fails++;
            $display("FAIL lfsr_phase_len: got %0d expected %0d", run,
                     (exp_q.size() == 0) ? -1 : exp_q[0]);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        started = 1'b1;
        run     = 1;
        prev    = o_clk;
      end else begin
        run++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_high();
    do_reset();
    lfsr_in = 8'hFF;
    en      = 1'b1;
    tick();
    tick();
    tick();
    tests++;
    if (o_clk !== 1'b1) begin
      fails++;
      $display("FAIL midhigh_before: got clk=%b expected 1", o_clk);
    end
    rst = 1'b1;
    tick();
    tests++;
    if ({o_clk, o_rise, o_fall, o_busy} !== 4'b0000) begin
      fails++;
      $display("FAIL midhigh_reset: got clk/rise/fall/busy=%b expected 0000",
               {o_clk, o_rise, o_fall, o_busy});
    end
    rst = 1'b0;
    tick();
    tests++;
    if ({o_clk, o_rise, o_fall, o_busy} !== 4'b1101) begin
      fails++;
      $display("FAIL midhigh_restart: got clk/rise/fall/busy=%b expected 1101",
               {o_clk, o_rise, o_fall, o_busy});
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      en      = ($urandom_range(0, 9) < ((c / 500) % 2 == 0 ? 8 : 2));
      lfsr_in = 8'($urandom);
      tick();
      tests++;
      if ({o_clk, o_rise, o_fall, o_busy} !== {m_clk, m_rise, m_fall, m_active}) begin
        fails++;
        $display("FAIL random_outputs cycle %0d: got clk/rise/fall/busy=%b expected %b", c,
                 {o_clk, o_rise, o_fall, o_busy}, {m_clk, m_rise, m_fall, m_active});
      end
    end
    rst = 1'b0;
    en  = 1'b0;
  endtask

`ifdef RANDCLK_EDGE_CNT_EN
  task automatic test_edge_cnt();
    int guard = 0;
    do_reset();
    lfsr_in = 8'hF8;
    en      = 1'b1;
    for (int t = 0; t < 40; t++) tick();
    tests++;
    if (o_edge_cnt !== 16'd10) begin
      fails++;
      $display("FAIL edge_cnt_ten: got %0d expected 10", o_edge_cnt);
    end
    en = 1'b0;
    while (o_busy && guard < 50) begin
      tick();
      guard++;
    end
    tests++;
    if (o_busy !== 1'b0) begin
      fails++;
      $display("FAIL edge_cnt_idle_timeout: got busy=%b expected 0", o_busy);
    end
    force dut.edge_cnt = 16'hFFFE;
    tick();
    release dut.edge_cnt;
    en = 1'b1;
    for (int t = 0; t < 12; t++) tick();
    tests++;
    if (o_edge_cnt !== 16'hFFFF) begin
      fails++;
      $display("FAIL edge_cnt_saturate: got %h expected ffff", o_edge_cnt);
    end
    en = 1'b0;
  endtask
`endif

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    lfsr_in  = 8'h00;
    m_active = 1'b0;
    m_clk    = 1'b0;
    m_rise   = 1'b0;
    m_fall   = 1'b0;
    m_left   = 0;
    test_reset();
    test_single_period();
    test_extremes();
    test_lfsr_driven();
    test_reset_mid_high();
    test_random();
`ifdef RANDCLK_EDGE_CNT_EN
    test_edge_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/random_clk_gen.md
# random_clk_gen

Random-period clock generator that sits directly downstream of the 8-bit free-running LFSR in the random-clock subsystem. At every half-period boundary it samples the LFSR output and derives the length of the next high or low phase from it. It emits a glitch-free registered clock-like waveform, `o_clk`, plus single-cycle edge strobes, for clocking stimulus or enable-gating in test structures. All logic runs on the system clock; `o_clk` is a data signal and is not used as a clock inside this block.

## Interface
- `BW_LFSR`, 8, width of the sampled LFSR word
- `RANGE_BITS`, 3, number of LFSR LSBs used as the random half-period increment (1..BW_LFSR)
- `MIN_HALF`, 2, minimum half-period in system cycles (≥1)
- `BW_CNT`, 8, phase-counter width; must satisfy MIN_HALF + 2^RANGE_BITS − 1 < 2^BW_CNT
- `i_clk`  in  1  system clock; everything is on the rising edge
- `i_rst`  in  1  reset, synchronous, active-high
- `i_en`  in  1  run request
- `i_lfsr`  in  BW_LFSR  LFSR output; a new value is present every cycle
- `o_clk`  out  1  generated random-period waveform, registered
- `o_rise`  out  1  one-cycle pulse in the first cycle `o_clk` is 1
- `o_fall`  out  1  one-cycle pulse in the first cycle `o_clk` is 0 after a high phase
- `o_busy`  out  1  1 whenever state ≠ IDLE
- `o_edge_cnt`  out  16  rising-edge count; present only with `RANDCLK_EDGE_CNT_EN`

## Operation
- **Phase length:** N = MIN_HALF + i_lfsr[RANGE_BITS-1:0], sampled at the edge that enters the phase.
  - Range is MIN_HALF .. MIN_HALF + 2^RANGE_BITS − 1.
  - The phase counter is loaded with N−1 and decrements to 0; unsigned, no wrap.
- **States:** IDLE, HIGH, LOW. `o_clk` = 1 only in HIGH.
- **Reset:** state IDLE; `o_clk`, `o_rise`, `o_fall` and `o_busy` = 0; counter = 0; `o_edge_cnt` = 0.
- **IDLE:** if `i_en`=1, sample N, go to HIGH and assert `o_rise`. Otherwise stay in IDLE.
- **HIGH:**
  - counter ≠ 0: decrement.
  - counter = 0: sample N, go to LOW, assert `o_fall`.
- **LOW:**
  - counter ≠ 0: decrement.
  - counter = 0 and `i_en`=1: sample N, go to HIGH, assert `o_rise`.
  - counter = 0 and `i_en`=0: go to IDLE, no strobe.
- **`i_en` deasserted mid-period:** the current HIGH and LOW phases complete at full length. No truncated pulses.
- **`i_en` reasserted during the final LOW:** takes effect only at the LOW→HIGH boundary.
- **`i_rst` mid-operation:** has priority over every transition. All outputs are 0 in the following cycle and the state is IDLE.
- **`i_lfsr`:** treated as arbitrary data. An all-zero value gives N = MIN_HALF; it is not an error.

## Timing
- Latency from `i_en` to output: `i_en`=1 sampled at edge k → `o_clk`=1 and `o_rise`=1 during cycle k+1.
- The high phase lasts exactly N_h cycles and the low phase exactly N_l cycles. Each N comes from `i_lfsr` at the transition edge.
- `o_rise` and `o_fall` are each 1 cycle wide, aligned with the `o_clk` transition, and never asserted together.
- Minimum output period = 2·MIN_HALF cycles.
- `o_busy` rises with the first `o_rise`. It falls in the cycle after the last LOW phase ends.

## Configuration
- **`RANDCLK_EDGE_CNT_EN` defined:**
  - Port `o_edge_cnt[15:0]` exists.
  - It increments in the cycle `o_rise` is asserted and saturates at 16'hFFFF.
  - It is cleared only by `i_rst`.
- **`RANDCLK_EDGE_CNT_EN` undefined:** the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use default parameters.
- **Reset values:** hold `i_rst`=1 for 3 cycles with `i_en`=1 → all outputs 0 throughout; `o_busy`=0.
- **Single period, then stop:**
  - Stimulus: `i_lfsr`=8'h05 held, `i_en` pulsed 1 cycle.
  - Response: `o_clk` high 7 cycles, low 7 cycles, then IDLE.
  - Exactly one `o_rise` and one `o_fall`; `o_busy` high for 14 cycles.
- **Phase-length extremes:** `i_lfsr`=8'hF8 → 2-cycle phases; `i_lfsr`=8'hFF → 9-cycle phases; `i_en` held 1.
- **Driven by the LFSR (SEED=1), `i_en`=1 for 500 cycles:**
  - Every measured phase length equals 2 + (LFSR value at the transition edge)[2:0].
  - No phase is shorter than 2 cycles.
- **Reset mid-HIGH:**
  - Stimulus: assert `i_rst` in the 3rd cycle of a 9-cycle high phase.
  - Response: next cycle `o_clk`=0, `o_busy`=0, no `o_fall`.
  - After reset releases with `i_en`=1, `o_rise` occurs one cycle later.
- **Edge count (`RANDCLK_EDGE_CNT_EN`):**
  - 10 full periods → `o_edge_cnt`=10.
  - Force the count to 16'hFFFE, then run 3 more rises → it holds at 16'hFFFF.
